sumfour_sched: RTL

Scheduler that shares one CNT_W-bit adder between two counter channels and owns the two channel counts (o_cnt_1, o_cnt_2). Each requester raises a request and receives a one-cycle acknowledge once its count has been updated. Requests are served by a 2-way round-robin arbiter. Each update adds a per-request step in either wrap or saturate mode. The block sits directly above the two-counter datapath and drives the same o_cnt_1/o_cnt_2 outputs the existing bench observes.

---
 rtl/sumfour_pkg.sv | 17 +
 rtl/rr_arb2.sv | 33 +++
 rtl/sumfour_sched.sv | 118 +++++++++++
 3 files changed

// File: rtl/sumfour_pkg.sv
// Shared types for the two-channel shared-adder counter scheduler.
package sumfour_pkg;

  localparam int CNT_W_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADD  = 2'd1,
    ST_ACK  = 2'd2
  } state_t;

  typedef enum logic {
    CH1 = 1'b0,
    CH2 = 1'b1
  } ch_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; req[0] is channel 1, req[1] is channel 2.
module rr_arb2
  import sumfour_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       i_clr,
  input  logic [1:0] req,
  input  logic       grant_en,
  output logic [1:0] gnt
);

  ch_t last;

  // On a tie the channel not granted last wins.
  always_comb begin
    gnt = 2'b00;
    if (req[0] && (!req[1] || last == CH2))
      gnt = 2'b01;
    else if (req[1])
      gnt = 2'b10;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      last <= CH2;
    else if (i_clr)
      last <= CH2;
    else if (grant_en)
      last <= gnt[1] ? CH2 : CH1;
  end

endmodule

// File: rtl/sumfour_sched.sv
// Shares one CNT_W-bit adder between two channel counts, with wrap/saturate
// update and a one-cycle ack per completed request.
//
//   state   | meaning
//   ST_IDLE | waiting for a request; grant and latch operands
//   ST_ADD  | form count + step and carry
//   ST_ACK  | write selected count, pulse ack/ovf
module sumfour_sched
  import sumfour_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clr,
  input  logic             i_req_1,
  input  logic             i_req_2,
  input  logic [CNT_W-1:0] i_step,
  input  logic             i_sat,
  output logic [CNT_W-1:0] o_cnt_1,
  output logic [CNT_W-1:0] o_cnt_2,
  output logic             o_ack_1,
  output logic             o_ack_2,
  output logic             o_ovf_1,
  output logic             o_ovf_2,
  output logic             o_busy
);

  state_t           state;
  ch_t              sel;
  logic [CNT_W-1:0] step_lat;
  logic             sat_lat;
  logic [CNT_W:0]   sum;
  logic [CNT_W-1:0] wdata;
  logic [1:0]       gnt;
  logic             grant_en;

  assign grant_en = (state == ST_IDLE) && (|gnt) && !i_clr;

  rr_arb2 u_arb (
    .clk      (clk),
    .rst      (rst),
    .i_clr    (i_clr),
    .req      ({i_req_2, i_req_1}),
    .grant_en (grant_en),
    .gnt      (gnt)
  );

  assign wdata = (sat_lat && sum[CNT_W]) ? {CNT_W{1'b1}} : sum[CNT_W-1:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_IDLE;
      sel      <= CH1;
      step_lat <= '0;
      sat_lat  <= 1'b0;
      sum      <= '0;
      o_cnt_1  <= '0;
      o_cnt_2  <= '0;
      o_ack_1  <= 1'b0;
      o_ack_2  <= 1'b0;
      o_ovf_1  <= 1'b0;
      o_ovf_2  <= 1'b0;
      o_busy   <= 1'b0;
    end else if (i_clr) begin
      state    <= ST_IDLE;
      sel      <= CH1;
      step_lat <= '0;
      sat_lat  <= 1'b0;
      sum      <= '0;
      o_cnt_1  <= '0;
      o_cnt_2  <= '0;
      o_ack_1  <= 1'b0;
      o_ack_2  <= 1'b0;
      o_ovf_1  <= 1'b0;
      o_ovf_2  <= 1'b0;
      o_busy   <= 1'b0;
    end else begin
      o_ack_1 <= 1'b0;
      o_ack_2 <= 1'b0;
      o_ovf_1 <= 1'b0;
      o_ovf_2 <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (grant_en) begin
            sel      <= gnt[0] ? CH1 : CH2;
            step_lat <= i_step;
            sat_lat  <= i_sat;
            state    <= ST_ADD;
            o_busy   <= 1'b1;
          end
        end
        ST_ADD: begin
          sum   <= {1'b0, (sel == CH2) ? o_cnt_2 : o_cnt_1} + {1'b0, step_lat};
          state <= ST_ACK;
        end
        ST_ACK: begin
          if (sel == CH1) begin
            o_cnt_1 <= wdata;
            o_ack_1 <= 1'b1;
            o_ovf_1 <= sum[CNT_W];
          end else begin
            o_cnt_2 <= wdata;
            o_ack_2 <= 1'b1;
            o_ovf_2 <= sum[CNT_W];
          end
          state  <= ST_IDLE;
          o_busy <= 1'b0;
        end
        default: begin
          state  <= ST_IDLE;
          o_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule
